// File: rtl/mandelbrot_iter.sv
// Mandelbrot iteration engine: iterates Z <- Z^2 + C from Z = 0, one step per
// clock, and reports whether |Z|^2 exceeded 4 and at which iteration index.
module mandelbrot_iter #(
  parameter int WIDTH    = 16,
  parameter int FRAC     = 13,
  parameter int MAX_ITER = 32,
  parameter int ITER_W   = $clog2(MAX_ITER + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_start,
  input  logic signed [WIDTH-1:0] i_cr,
  input  logic signed [WIDTH-1:0] i_ci,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_unbounded,
  output logic [ITER_W-1:0]       o_iter
);

  localparam int PW    = 2 * WIDTH;          // full product width
  localparam int ESC_W = 2 * WIDTH - FRAC + 1; // escape sum width, cannot overflow
  localparam int SW    = 2 * WIDTH + 2;      // headroom for the update sums

  localparam logic signed [ESC_W-1:0] ESC_LIMIT = ESC_W'(4 << FRAC);
  localparam logic signed [SW-1:0]    SAT_MAX   = SW'((2 ** (WIDTH - 1)) - 1);
  localparam logic signed [SW-1:0]    SAT_MIN   = -SAT_MAX - SW'(1);
  localparam logic [ITER_W-1:0]       ITER_MAX  = ITER_W'(MAX_ITER);

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic signed [WIDTH-1:0] zr, zi, cr, ci;
  logic [ITER_W-1:0]       n;
  logic                    unbounded_r;
  logic [ITER_W-1:0]       iter_r;

  logic signed [PW-1:0]    prod_rr, prod_ii, prod_ri;
  logic signed [PW-1:0]    sq_r, sq_i, two_ri;
  logic signed [ESC_W-1:0] esc_sum;
  logic                    escape;
  logic                    at_limit;
  logic signed [SW-1:0]    zr_wide, zi_wide;
  logic signed [WIDTH-1:0] zr_nxt, zi_nxt;

  function automatic logic signed [WIDTH-1:0] sat(input logic signed [SW-1:0] v);
    logic signed [SW-1:0] c;
    if (v > SAT_MAX)      c = SAT_MAX;
    else if (v < SAT_MIN) c = SAT_MIN;
    else                  c = v;
    return c[WIDTH-1:0];
  endfunction

  // Squaring datapath, escape test and saturated next-Z.
  always_comb begin
    prod_rr  = PW'(zr) * PW'(zr);
    prod_ii  = PW'(zi) * PW'(zi);
    prod_ri  = PW'(zr) * PW'(zi);
    sq_r     = prod_rr >>> FRAC;
    sq_i     = prod_ii >>> FRAC;
    two_ri   = prod_ri >>> (FRAC - 1);
    esc_sum  = ESC_W'(sq_r) + ESC_W'(sq_i);
    escape   = (esc_sum > ESC_LIMIT);
    at_limit = (n == ITER_MAX);
    zr_wide  = SW'(sq_r) - SW'(sq_i) + SW'(cr);
    zi_wide  = SW'(two_ri) + SW'(ci);
    zr_nxt   = sat(zr_wide);
    zi_nxt   = sat(zi_wide);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and status outputs.
  always_comb begin
    state_nxt = state;
    o_busy    = 1'b0;
    o_done    = 1'b0;
    unique case (state)
      IDLE: if (i_start) state_nxt = ITER;
      ITER: begin
        o_busy = 1'b1;
        if (escape || at_limit) state_nxt = DONE;
      end
      DONE: begin
        o_done    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Iteration datapath and held results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zr          <= '0;
      zi          <= '0;
      cr          <= '0;
      ci          <= '0;
      n           <= '0;
      unbounded_r <= 1'b0;
      iter_r      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            cr          <= i_cr;
            ci          <= i_ci;
            zr          <= '0;
            zi          <= '0;
            n           <= '0;
            unbounded_r <= 1'b0;
            iter_r      <= '0;
          end
        end
        ITER: begin
          if (escape) begin
            unbounded_r <= 1'b1;
            iter_r      <= n;
          end else if (at_limit) begin
            unbounded_r <= 1'b0;
            iter_r      <= ITER_MAX;
          end else begin
            zr <= zr_nxt;
            zi <= zi_nxt;
            n  <= n + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_unbounded = unbounded_r;
  assign o_iter      = iter_r;

endmodule

// File: tb/tb_mandelbrot_iter.sv
// Self-checking bench for mandelbrot_iter: a plain-arithmetic escape-time
// model predicts each run's outcome; a compare process checks every cycle.
module tb_mandelbrot_iter;

  localparam int WIDTH    = 16;
  localparam int FRAC     = 13;
  localparam int MAX_ITER = 32;
  localparam int ITER_W   = $clog2(MAX_ITER + 1);

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    i_start = 1'b0;
  logic signed [WIDTH-1:0] i_cr = '0;
  logic signed [WIDTH-1:0] i_ci = '0;
  logic                    o_busy, o_done, o_unbounded;
  logic [ITER_W-1:0]       o_iter;

  int n_checks = 0;
  int n_fail   = 0;

  logic              exp_busy = 1'b0;
  logic              exp_done = 1'b0;
  logic              exp_unb  = 1'b0;
  logic [ITER_W-1:0] exp_iter = '0;
  bit                chk      = 1'b0;

  mandelbrot_iter #(
    .WIDTH(WIDTH),
    .FRAC(FRAC),
    .MAX_ITER(MAX_ITER),
    .ITER_W(ITER_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_start(i_start),
    .i_cr(i_cr),
    .i_ci(i_ci),
    .o_busy(o_busy),
    .o_done(o_done),
    .o_unbounded(o_unbounded),
    .o_iter(o_iter)
  );

  always #5 clk = ~clk;

  // Escape-time reference in wide integers: returns the terminating index
  // and whether the orbit left the radius-2 disk.
  function automatic void model(input int cr, input int ci, output int it, output bit unb);
    longint zr = 0, zi = 0, rr, ii, nr, ni;
    longint hi = 32767, lo = -32768;
    it  = MAX_ITER;
    unb = 1'b0;
    for (int n = 0; n <= MAX_ITER; n++) begin
      rr = (zr * zr) >>> FRAC;
      ii = (zi * zi) >>> FRAC;
      if (rr + ii > (longint'(4) << FRAC)) begin
        it  = n;
        unb = 1'b1;
        return;
      end
      if (n == MAX_ITER) return;
      nr = rr - ii + cr;
      ni = ((zr * zi) >>> (FRAC - 1)) + ci;
      zr = (nr > hi) ? hi : ((nr < lo) ? lo : nr);
      zi = (ni > hi) ? hi : ((ni < lo) ? lo : ni);
    end
  endfunction

  task automatic check_bit(input string name, input logic act, input logic req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, req, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic check_outputs();
    check_bit("o_busy", o_busy, exp_busy);
    check_bit("o_done", o_done, exp_done);
    check_bit("o_unbounded", o_unbounded, exp_unb);
    n_checks++;
    if (o_iter !== exp_iter) begin
      n_fail++;
      $display("FAIL o_iter: got %0d expected %0d at %0t", o_iter, exp_iter, $time);
    end
  endtask

  // Compare process: every cycle, away from the rising edge.
  always @(negedge clk) if (chk) check_outputs();

  task automatic set_idle();
    exp_busy = 1'b0;
    exp_done = 1'b0;
  endtask

  // Runs one point; hold=1 keeps i_start high and changes i_cr during the run.
  task automatic run_point(input int cr, input int ci, input int lit_iter,
                           input bit lit_unb, input bit hold);
    int mi;
    bit mu;
    model(cr, ci, mi, mu);
    check_int("model_iter", mi, lit_iter);
    check_bit("model_unb", mu, lit_unb);
    @(negedge clk);
    i_start = 1'b1;
    i_cr    = WIDTH'(cr);
    i_ci    = WIDTH'(ci);
    @(posedge clk); #1;
    exp_busy = 1'b1;
    exp_done = 1'b0;
    exp_unb  = 1'b0;
    exp_iter = '0;
    @(negedge clk);
    if (hold) i_cr = '0;
    else      i_start = 1'b0;
    repeat (mi) @(posedge clk);
    @(posedge clk); #1;
    exp_busy = 1'b0;
    exp_done = 1'b1;
    exp_unb  = mu;
    exp_iter = ITER_W'(mi);
    @(negedge clk);
    i_start = 1'b0;
    @(posedge clk); #1;
    set_idle();
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #2;
    check_outputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk = 1'b1;

    run_point(0, 0, 32, 1'b0, 1'b0);
    run_point(8192, 0, 3, 1'b1, 1'b0);
    run_point(-16384, 0, 32, 1'b0, 1'b0);
    run_point(0, 8192, 32, 1'b0, 1'b0);
    run_point(4096, 4096, 5, 1'b1, 1'b0);
    run_point(-8192, 0, 32, 1'b0, 1'b0);
    run_point(16384, 0, 2, 1'b1, 1'b1);

    // Reset in the middle of a C = 0 run, at n = 10.
    @(negedge clk);
    i_start = 1'b1;
    i_cr    = '0;
    i_ci    = '0;
    @(posedge clk); #1;
    exp_busy = 1'b1;
    exp_unb  = 1'b0;
    exp_iter = '0;
    @(negedge clk);
    i_start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    set_idle();
    exp_unb  = 1'b0;
    exp_iter = '0;
    check_outputs();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_point(8192, 0, 3, 1'b1, 1'b0);

    chk = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mandelbrot_iter.md
Name: mandelbrot_iter

Overview:
- Iteration engine inside tt_um_mandelbrot_accel, directly downstream of the Cr/Ci byte loader.
- Takes a loaded constant C = Cr + j·Ci and iterates Z(n+1) = Z(n)² + C from Z(0) = 0, one iteration per clock.
- Reports whether the point escaped (|Z|² > 4) and after how many iterations; o_unbounded drives uo_out[0].

Parameters:
- WIDTH, 16, signed two's-complement width of Cr, Ci, Zr, Zi.
- FRAC, 13, fraction bits (Q2.13: range −4.0 … +3.99988, 1.0 = 8192).
- MAX_ITER, 32, iteration limit; a point that never escapes reports o_iter = MAX_ITER.
- ITER_W, $clog2(MAX_ITER+1), width of o_iter.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous reset, active-high.
- i_start  in  1  start request; sampled only in IDLE.
- i_cr  in  WIDTH  real part of C, signed; captured on accepted start.
- i_ci  in  WIDTH  imaginary part of C, signed; captured on accepted start.
- o_busy  out  1  high while in ITER.
- o_done  out  1  one-cycle pulse, high while in DONE.
- o_unbounded  out  1  1 = escaped; held until the next accepted start.
- o_iter  out  ITER_W  iteration index at termination; held until the next accepted start.

Behaviour:
- Reset (async, any state, including mid-iteration):
  - state = IDLE; Zr = Zi = Cr = Ci = 0; n = 0.
  - o_busy = o_done = o_unbounded = 0; o_iter = 0.
- States: IDLE, ITER, DONE.
- IDLE:
  - On i_start = 1: capture i_cr and i_ci; clear Zr, Zi, n, o_unbounded, o_iter; go to ITER.
  - Otherwise stay in IDLE.
- ITER (one cycle per n). On each edge, in priority order:
  - Escape check: sum of squares (Zr² + Zi²) > 4.0 → o_unbounded = 1, o_iter = n, go to DONE. Exactly 4.0 is not an escape.
  - Limit check: else if n == MAX_ITER → o_unbounded = 0, o_iter = MAX_ITER, go to DONE.
  - Update: else Zr ← sat(Zr² − Zi² + Cr), Zi ← sat(2·Zr·Zi + Ci), n ← n + 1.
- DONE: o_done = 1 for exactly one cycle, then unconditional return to IDLE. i_start is ignored in DONE.
- i_start in ITER or DONE is ignored: C is not re-captured and the run is not restarted.
- Arithmetic:
  - Full 2·WIDTH signed products.
  - Zr² = (Zr·Zr) >>> FRAC, Zi² = (Zi·Zi) >>> FRAC, 2·Zr·Zi = (Zr·Zi) >>> (FRAC−1). Arithmetic shift, truncation toward −inf.
  - The escape sum is formed at 2·WIDTH−FRAC+1 bits with no overflow and compared against 4 << FRAC.
  - sat() clamps to [−2^(WIDTH−1), 2^(WIDTH−1)−1]. A saturated Z always satisfies the escape test on the next cycle.
- Latency: o_done is high in cycle o_iter + 2 after the edge that samples i_start. Worst case is MAX_ITER + 2.

Test Plan:
- C = (0, 0), MAX_ITER = 32: start → o_busy for 33 cycles; o_done at cycle 34; o_unbounded = 0, o_iter = 32.
- C = (1.0, 0) = (8192, 0): Z sequence 0, 1, 2, 5 saturated to 32767 → o_unbounded = 1, o_iter = 3, o_done at cycle 5.
- C = (−2.0, 0) = (−16384, 0): Z settles at 2.0 with |Z|² = 4 exactly, never > 4 → o_unbounded = 0, o_iter = 32 (boundary check).
- C = (0, 1.0) = (0, 8192): Z cycles 0, j, −1+j, −j, −1+j, … → bounded, o_iter = 32.
- C = (2.0, 0), with i_start held high and i_cr changed to 0 during ITER: change and start are ignored → o_iter = 2, o_unbounded = 1. The next start is accepted only after DONE.
- Run C = (0, 0), assert rst for 1 cycle at n = 10: all outputs 0 immediately. A new start with C = (1.0, 0) then gives o_iter = 3, o_unbounded = 1.
